// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers for the MIPS150 execute stage.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiply, divide stays iterative.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, hi_q, lo_q;
    logic                 is_div_q, neg_res_q, neg_rem_q, done_q;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       add_sum, sub_diff;
    logic [2*WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

    always_comb begin
        a_neg = ~op[0] & A[WIDTH-1];
        b_neg = ~op[0] & B[WIDTH-1];
        a_abs = a_neg ? -A : A;
        b_abs = b_neg ? -B : B;
    end

`ifdef MULDIV_FAST_MULT_EN
    logic signed [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u, fast_prod;

    always_comb begin
        prod_s    = $signed(A) * $signed(B);
        prod_u    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        fast_prod = op[0] ? prod_u : prod_s;
    end
`endif

    // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (is_div_q)
            acc_d = sub_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        mul_res = neg_res_q ? -acc_q : acc_q;
        quo     = acc_q[WIDTH-1:0];
        rem     = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_lo = (opnd_q == '0) ? '1 : (neg_res_q ? -quo : quo);
            fix_hi = neg_rem_q ? -rem : rem;
        end else begin
            fix_lo = mul_res[WIDTH-1:0];
            fix_hi = mul_res[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= '0;
                        if (op[1]) begin
                            acc_q   <= {{WIDTH{1'b0}}, a_abs};
                            opnd_q  <= b_abs;
                            state_q <= CALC;
                        end else begin
`ifdef MULDIV_FAST_MULT_EN
                            acc_q     <= fast_prod;
                            opnd_q    <= a_abs;
                            neg_res_q <= 1'b0;
                            state_q   <= FIX;
`else
                            acc_q   <= {{WIDTH{1'b0}}, b_abs};
                            opnd_q  <= a_abs;
                            state_q <= CALC;
`endif
                        end
                    end else begin
                        if (mthi) hi_q <= A;
                        if (mtlo) lo_q <= A;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: reference results from native SV arithmetic, latency and control checks.
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, start, mthi, mtlo;
    logic [1:0]    op;
    logic [W-1:0]  A, B;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   sb[$];
    logic [W-1:0]  lo_before;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic signed [31:0] qs, rs;
        case (o)
            2'd0: begin
                ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return ps;
            end
            2'd1: return {32'h0, a} * {32'h0, b};
            2'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qs = $signed(a) / $signed(b);
                rs = $signed(a) % $signed(b);
                return {rs, qs};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic mv);
        @(posedge clk); #1;
        lo_before = lo;
        start = 1'b1; op = o; A = a; B = b; mtlo = mv;
        sb.push_back(model(o, a, b));
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mv, input string tag);
        int lat, nb, exp_lat, exp_busy;
        bit fast_op;
        fast_op  = FAST && !o[1];
        exp_lat  = fast_op ? 2 : W + 2;
        exp_busy = fast_op ? 1 : W + 1;
        lat = 0; nb = 0;
        launch(o, a, b, mv);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (mv && n == 1) check_eq({tag, "_mv_drop"}, 64'(lo), 64'(lo_before));
            if (busy) nb++;
            if (done) begin lat = n; break; end
        end
        if (lat == 0) begin
            check_eq({tag, "_timeout"}, 64'd0, 64'd1);
            void'(sb.pop_front());
        end else begin
            if (sb.size() == 0) check_eq({tag, "_sb_underflow"}, 64'd0, 64'd1);
            else check_eq(tag, {hi, lo}, sb.pop_front());
            check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
            check_eq({tag, "_busy"}, 64'(nb), 64'(exp_busy));
            @(negedge clk);
            check_eq({tag, "_pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, lat;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'd0; A = '0; B = '0;
        #12;
        check_eq("reset_hilo", {hi, lo}, 64'h0);
        check_eq("reset_ctl", {62'h0, busy, done}, 64'h0);
        @(negedge clk); rst_n = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_neg");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        run_op(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, "div_negneg");
        run_op(2'd3, 32'd7, 32'd0, 1'b0, "divu_zero");
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, 1'b0, "div_zero_neg");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(2'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_one");

        // second start and mtlo while busy must both be ignored
        launch(2'd3, 32'd100, 32'd7, 1'b0);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 5) begin start = 1'b1; op = 2'd0; A = 32'd2; B = 32'd3; mtlo = 1'b1; end
            if (n == 6) begin start = 1'b0; mtlo = 1'b0; end
            if (n == 10) check_eq("busy_mtlo_ignored", 64'(lo), 64'(lo_before));
            if (done) begin lat = n; break; end
        end
        check_eq("restart_lat", 64'(lat), 64'(W + 2));
        if (sb.size() != 0) check_eq("restart_result", {hi, lo}, sb.pop_front());
        cnt = 0;
        for (int n = 0; n < 40; n++) begin @(negedge clk); if (done) cnt++; end
        check_eq("no_second_done", 64'(cnt), 64'd0);

        // reset in mid-operation aborts with no done pulse
        launch(2'd2, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_hilo", {hi, lo}, 64'h0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        void'(sb.pop_back());
        cnt = 0;
        for (int n = 0; n < 40; n++) begin @(negedge clk); if (done) cnt++; end
        check_eq("abort_no_done", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        run_op(2'd2, 32'd1000, 32'hFFFF_FFFD, 1'b0, "after_reset");

        // moves in IDLE
        @(posedge clk); #1 mthi = 1'b1; A = 32'h1234;
        @(posedge clk); #1 mthi = 1'b0;
        check_eq("mthi", 64'(hi), 64'h1234);
        mtlo = 1'b1; A = 32'h5678;
        @(posedge clk); #1 mtlo = 1'b0;
        check_eq("mtlo", 64'(lo), 64'h5678);
        check_eq("mtlo_hi_kept", 64'(hi), 64'h1234);
        run_op(2'd1, 32'd6, 32'd7, 1'b1, "start_mtlo");

        for (int k = 0; k < 8; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k == 3) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            run_op(ro, ra, rb, 1'b0, "random");
        end

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
